// File: rtl/secuenciador_int.sv
// secuenciador_int: interrupt entry/return sequencer between decoder and datapath.
// Passes the decoder control word through, except for a one-cycle ENTRY
// (squash + push PC + load vector) and the RETI cycle (pop + return strobe).
module secuenciador_int #(
    parameter int          N_INT   = 8,
    parameter logic [7:0]  OP_RETI = 8'hFE,
    localparam int         IW      = (N_INT > 1) ? $clog2(N_INT) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_INT-1:0] int_req,
    input  logic [N_INT-1:0] int_en,
    input  logic             gie,
    input  logic             stack_full,
    input  logic [7:0]       opcode,
    input  logic             uc_push,
    input  logic             uc_pop,
    input  logic             uc_s_pila,
    input  logic             uc_we3,
    input  logic             uc_wez,
    input  logic             uc_oe,
    input  logic [1:0]       uc_s_inc,
    output logic             push,
    output logic             pop,
    output logic             s_pila,
    output logic             we3,
    output logic             wez,
    output logic             oe,
    output logic [1:0]       s_inc,
    output logic [N_INT-1:0] s_calli,
    output logic [N_INT-1:0] s_reti,
    output logic             in_service,
    output logic [IW-1:0]    int_idx
);

    typedef enum logic [1:0] {IDLE, ENTRY, ISR, GUARD} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    int_idx_q, int_idx_d;
    logic [N_INT-1:0] win;
    logic [IW-1:0]    win_idx;
    logic [N_INT-1:0] idx_onehot;

    // One-hot decode of the latched line index, shared by both strobes
    for (genvar gi = 0; gi < N_INT; gi++) begin : g_onehot
        assign idx_onehot[gi] = (int_idx_q == IW'(gi));
    end

    // Qualified requests and lowest-index (highest-priority) winner
    always_comb begin
        win     = gie ? (int_req & int_en) : '0;
        win_idx = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (win[i]) win_idx = IW'(i);
        end
    end

    // Next-state and index latch; entry only from IDLE, never nested
    always_comb begin
        state_d   = state_q;
        int_idx_d = int_idx_q;
        case (state_q)
            IDLE: begin
                if ((win != '0) && !stack_full) begin
                    state_d   = ENTRY;
                    int_idx_d = win_idx;
                end
            end
            ENTRY: state_d = ISR;
            ISR:   if (opcode == OP_RETI) state_d = GUARD;
            GUARD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and serviced-line registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            int_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            int_idx_q <= int_idx_d;
        end
    end

    // Control word: pass-through, overridden on ENTRY and on the RETI cycle;
    // everything forced low while reset is held, whatever the decoder says
    always_comb begin
        push       = uc_push;
        pop        = uc_pop;
        s_pila     = uc_s_pila;
        we3        = uc_we3;
        wez        = uc_wez;
        oe         = uc_oe;
        s_inc      = uc_s_inc;
        s_calli    = '0;
        s_reti     = '0;
        in_service = (state_q == ISR);
        int_idx    = int_idx_q;
        case (state_q)
            ENTRY: begin
                // Squash the fetched instruction and push its own PC so it re-executes
                push    = 1'b1;
                pop     = 1'b0;
                s_pila  = 1'b0;
                we3     = 1'b0;
                wez     = 1'b0;
                oe      = 1'b0;
                s_inc   = 2'b10;
                s_calli = idx_onehot;
            end
            ISR: begin
                if (opcode == OP_RETI) begin
                    push   = 1'b0;
                    pop    = 1'b1;
                    s_pila = 1'b1;
                    we3    = 1'b0;
                    wez    = 1'b0;
                    oe     = 1'b0;
                    s_reti = idx_onehot;
                end
            end
            default: ;
        endcase
        if (reset) begin
            push       = 1'b0;
            pop        = 1'b0;
            s_pila     = 1'b0;
            we3        = 1'b0;
            wez        = 1'b0;
            oe         = 1'b0;
            s_inc      = 2'b00;
            s_calli    = '0;
            s_reti     = '0;
            in_service = 1'b0;
            int_idx    = '0;
        end
    end

endmodule

// File: tb/tb_secuenciador_int.sv
// Scoreboard bench for secuenciador_int: the driver pushes the hand-computed
// expected output word for each cycle, the monitor pops and compares it on
// the falling edge. Control word encoding: {push,pop,s_pila,we3,wez,oe,s_inc}.
module tb_secuenciador_int;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] int_req = '0, int_en = '0;
    logic       gie = 1'b0, stack_full = 1'b0;
    logic [7:0] opcode = '0;
    logic       uc_push, uc_pop, uc_s_pila, uc_we3, uc_wez, uc_oe;
    logic [1:0] uc_s_inc;
    logic       push, pop, s_pila, we3, wez, oe;
    logic [1:0] s_inc;
    logic [7:0] s_calli, s_reti;
    logic       in_service;
    logic [2:0] int_idx;

    logic [7:0] uc_word = 8'hFF;
    assign {uc_push, uc_pop, uc_s_pila, uc_we3, uc_wez, uc_oe, uc_s_inc} = uc_word;

    secuenciador_int #(.N_INT(8), .OP_RETI(8'hFE)) dut (
        .clk(clk), .reset(reset), .int_req(int_req), .int_en(int_en),
        .gie(gie), .stack_full(stack_full), .opcode(opcode),
        .uc_push(uc_push), .uc_pop(uc_pop), .uc_s_pila(uc_s_pila),
        .uc_we3(uc_we3), .uc_wez(uc_wez), .uc_oe(uc_oe), .uc_s_inc(uc_s_inc),
        .push(push), .pop(pop), .s_pila(s_pila), .we3(we3), .wez(wez), .oe(oe),
        .s_inc(s_inc), .s_calli(s_calli), .s_reti(s_reti),
        .in_service(in_service), .int_idx(int_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [27:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: one comparison per cycle against the oldest pending expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [27:0] act;
            e   = exp_q.pop_front();
            act = {push, pop, s_pila, we3, wez, oe, s_inc, s_calli, s_reti, in_service, int_idx};
            n_checks++;
            if (act !== e.v) begin
                n_errors++;
                $display("FAIL %s: got ctrl=%h calli=%h reti=%h insvc=%b idx=%0d, expected ctrl=%h calli=%h reti=%h insvc=%b idx=%0d",
                         e.nm, act[27:20], act[19:12], act[11:4], act[3], act[2:0],
                         e.v[27:20], e.v[19:12], e.v[11:4], e.v[3], e.v[2:0]);
            end else begin
                $display("ok   %s: ctrl=%h calli=%h reti=%h insvc=%b idx=%0d",
                         e.nm, act[27:20], act[19:12], act[11:4], act[3], act[2:0]);
            end
        end
    end

    // Drive one cycle of decoder word, queue its expected response, advance
    task automatic cyc(input string nm, input logic [7:0] uc,
                       input logic [7:0] e_ctrl, input logic [7:0] e_calli,
                       input logic [7:0] e_reti, input logic e_ins, input logic [2:0] e_idx);
        exp_t e;
        uc_word = uc;
        e.nm = nm;
        e.v  = {e_ctrl, e_calli, e_reti, e_ins, e_idx};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset with every decoder bit high: all outputs low
        cyc("reset0", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        cyc("reset1", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        reset = 1'b0;
        cyc("pass_we3", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        cyc("pass_push", 8'h81, 8'h81, 8'h00, 8'h00, 1'b0, 3'd0);

        // Request 0001_0100 pulsed: lowest bit (2) wins
        gie = 1'b1; int_en = 8'hFF; int_req = 8'h14;
        cyc("idle_req14", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        int_req = 8'h00;
        cyc("entry2", 8'h13, 8'h82, 8'h04, 8'h00, 1'b0, 3'd2);
        cyc("isr2", 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'd2);
        opcode = 8'hFE;
        cyc("reti2", 8'h1C, 8'h60, 8'h00, 8'h04, 1'b1, 3'd2);
        opcode = 8'h00;
        cyc("guard2", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd2);
        cyc("idle2", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd2);

        // Line 3 serviced; line 0 requested in ISR (ignored) and held over RETI
        int_req = 8'h08;
        cyc("idle_req08", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd2);
        int_req = 8'h00;
        cyc("entry3", 8'h10, 8'h82, 8'h08, 8'h00, 1'b0, 3'd3);
        int_req = 8'h01;
        cyc("isr3_nonest", 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'd3);
        opcode = 8'hFE;
        cyc("reti3_req", 8'h10, 8'h60, 8'h00, 8'h08, 1'b1, 3'd3);
        opcode = 8'h00;
        cyc("guard3_req", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd3);
        cyc("idle3_req", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd3);
        cyc("entry0", 8'h10, 8'h82, 8'h01, 8'h00, 1'b0, 3'd0);
        int_req = 8'h00;
        cyc("isr0", 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'd0);
        opcode = 8'hFE;
        cyc("reti0", 8'h10, 8'h60, 8'h00, 8'h01, 1'b1, 3'd0);
        opcode = 8'h00;
        cyc("guard0", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        cyc("idle0", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);

        // Stack full blocks entry; release gives ENTRY on the next cycle
        stack_full = 1'b1; int_req = 8'h02;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("sfull_%0d", i), 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        stack_full = 1'b0;
        cyc("sfull_rel", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        cyc("entry1", 8'h10, 8'h82, 8'h02, 8'h00, 1'b0, 3'd1);
        int_req = 8'h00;
        cyc("isr1", 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'd1);
        opcode = 8'hFE;
        cyc("reti1", 8'h10, 8'h60, 8'h00, 8'h02, 1'b1, 3'd1);
        opcode = 8'h00;
        cyc("guard1", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd1);
        cyc("idle1", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd1);

        // Global disable, then per-line mask off: no entry
        gie = 1'b0; int_en = 8'hFF; int_req = 8'hFF;
        for (int i = 0; i < 20; i++)
            cyc($sformatf("gie0_%0d", i), 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd1);
        gie = 1'b1; int_en = 8'h00;
        for (int i = 0; i < 20; i++)
            cyc($sformatf("en0_%0d", i), 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd1);

        // Reset asserted in the middle of an ISR: no return strobe afterwards
        int_en = 8'hFF; int_req = 8'h80;
        cyc("idle_req80", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd1);
        int_req = 8'h00;
        cyc("entry7", 8'h10, 8'h82, 8'h80, 8'h00, 1'b0, 3'd7);
        cyc("isr7", 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 3'd7);
        reset = 1'b1; opcode = 8'hFE;
        cyc("rst_isr", 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
        reset = 1'b0;
        cyc("after_rst", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
        opcode = 8'h00;
        cyc("after_rst2", 8'h10, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);

        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
